// File: rtl/debug_host_bridge_if.sv
// Host byte streams and core debug port for debug_host_bridge.
// master is the bridge side, slave is the host/core side.
interface debug_host_bridge_if;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic [2:0] DEBUG_ADDR;
  logic [7:0] DEBUG_DIN;
  logic [7:0] DEBUG_DOUT;
  logic       DEBUG_RD;
  logic       DEBUG_WR;
  logic       BUSY;

  modport master (
    input  RX_DATA, RX_VALID, TX_READY, DEBUG_DOUT,
    output RX_READY, TX_DATA, TX_VALID,
    output DEBUG_ADDR, DEBUG_DIN, DEBUG_RD, DEBUG_WR, BUSY
  );

  modport slave (
    output RX_DATA, RX_VALID, TX_READY, DEBUG_DOUT,
    input  RX_READY, TX_DATA, TX_VALID,
    input  DEBUG_ADDR, DEBUG_DIN, DEBUG_RD, DEBUG_WR, BUSY
  );
endinterface

// File: rtl/debug_host_bridge.sv
// Serial host to core debug-port bridge: command bytes in,
// single-cycle register strobes out, read data / ACK back.
module debug_host_bridge #(
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] ACK_BYTE   = 8'hA5
) (
  input logic CLK,
  input logic RESET,
  debug_host_bridge_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_STROBE,
    ACK_SEND,
    RD_STROBE,
    RD_WAIT,
    RD_SEND
  } state_t;

  localparam logic [1:0] LAST = 2'(RD_LATENCY - 1);

  state_t     state, state_n;
  logic [2:0] addr, addr_n;
  logic [7:0] din, din_n;
  logic [2:0] cnt, cnt_n;
  logic       inc, inc_n;
  logic [1:0] wcnt, wcnt_n;
  logic [7:0] rdata, rdata_n;
  logic       rx_ok;
  logic       rx_fire;
  logic       tx_ack;
  logic       tx_rd;
  logic [7:0] tx_data;
  logic [2:0] addr_step;

  // Ready is masked by RESET so a handshake never lands on a reset edge.
  assign rx_ok   = !RESET && (state == IDLE || state == WR_DATA);
  assign rx_fire = rx_ok && bus.RX_VALID;
  assign tx_ack  = state == ACK_SEND;
  assign tx_rd   = state == RD_SEND;
  assign addr_step = addr + {2'b00, inc};

  always_comb begin
    tx_data = '0;
    unique case (1'b1)
      tx_ack:  tx_data = ACK_BYTE;
      tx_rd:   tx_data = rdata;
      default: tx_data = '0;
    endcase
  end

  assign bus.RX_READY   = rx_ok;
  assign bus.TX_VALID   = tx_ack || tx_rd;
  assign bus.TX_DATA    = tx_data;
  assign bus.DEBUG_ADDR = addr;
  assign bus.DEBUG_DIN  = din;
  assign bus.DEBUG_RD   = state == RD_STROBE;
  assign bus.DEBUG_WR   = state == WR_STROBE;
  assign bus.BUSY       = state != IDLE;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      addr  <= '0;
      din   <= '0;
      cnt   <= '0;
      inc   <= 1'b0;
      wcnt  <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      din   <= din_n;
      cnt   <= cnt_n;
      inc   <= inc_n;
      wcnt  <= wcnt_n;
      rdata <= rdata_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    din_n   = din;
    cnt_n   = cnt;
    inc_n   = inc;
    wcnt_n  = wcnt;
    rdata_n = rdata;
    unique case (state)
      IDLE: begin
        if (rx_fire) begin
          inc_n   = bus.RX_DATA[6];
          cnt_n   = bus.RX_DATA[5:3];
          addr_n  = bus.RX_DATA[2:0];
          state_n = bus.RX_DATA[7] ? WR_DATA : RD_STROBE;
        end
      end
      WR_DATA: begin
        if (rx_fire) begin
          din_n   = bus.RX_DATA;
          state_n = WR_STROBE;
        end
      end
      // Address moves after the strobe cycle, never during it.
      WR_STROBE: begin
        addr_n = addr_step;
        if (cnt == 3'd0) begin
          state_n = ACK_SEND;
        end else begin
          cnt_n   = cnt - 3'd1;
          state_n = WR_DATA;
        end
      end
      ACK_SEND: begin
        if (bus.TX_READY) state_n = IDLE;
      end
      RD_STROBE: begin
        wcnt_n  = '0;
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (wcnt == LAST) begin
          rdata_n = bus.DEBUG_DOUT;
          state_n = RD_SEND;
        end else begin
          wcnt_n = wcnt + 2'd1;
        end
      end
      RD_SEND: begin
        if (bus.TX_READY) begin
          addr_n = addr_step;
          if (cnt == 3'd0) begin
            state_n = IDLE;
          end else begin
            cnt_n   = cnt - 3'd1;
            state_n = RD_STROBE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
